// File: rtl/camera_stream_gen_if.sv
// Output side of camera_stream_gen: DVP-style byte, strobes, framing syncs and position counters.
// The generator drives the master modport; capture/measure logic listens on the slave modport.
interface camera_stream_gen_if;
  logic [7:0]  data_out;
  logic        valid_byte_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [12:0] hcount_out;
  logic [11:0] vcount_out;
  logic [15:0] frame_count_out;
  logic        busy_out;

  modport master (
    output data_out, valid_byte_out, hsync_out, vsync_out,
    output hcount_out, vcount_out, frame_count_out, busy_out
  );

  modport slave (
    input data_out, valid_byte_out, hsync_out, vsync_out,
    input hcount_out, vcount_out, frame_count_out, busy_out
  );
endinterface

// File: rtl/camera_stream_gen.sv
// Synthetic OV5640-style DVP source: one registered byte strobe every CLK_DIV cycles with HREF/VSYNC framing.
// First byte appears CLK_DIV+1 cycles after enable; free-running, no backpressure; enable only acts at frame boundaries.
module camera_stream_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 64,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 16,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                enable_in,
  input  logic [1:0]          pattern_sel_in,
  camera_stream_gen_if.master cam
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (CLK_DIV < 1 || H_BLANK < 1 || V_SYNC < 1 || H_ACTIVE < 0 || V_BACK < 0 ||
        V_ACTIVE < 0 || V_FRONT < 0 || H_TOTAL > 8192 || V_TOTAL > 4096) begin : g_bad_param
      $error("camera_stream_gen: geometry parameters out of range");
    end
  endgenerate

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [12:0] H_LAST    = 13'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  // Window bounds are one bit wider than the counters so an end bound equal to 2^n still compares correctly.
  localparam logic [13:0] H_ACT_END = 14'(H_ACTIVE);
  localparam logic [13:0] V_SYN_END = 14'(V_SYNC);
  localparam logic [13:0] V_ACT_BEG = 14'(V_SYNC + V_BACK);
  localparam logic [13:0] V_ACT_END = 14'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [12:0]      h_q;
  logic [11:0]      v_q;
  logic [1:0]       pat_q;
  logic [15:0]      frame_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             hsync_q;
  logic             vsync_q;
  logic [12:0]      hcount_q;
  logic [11:0]      vcount_q;
  logic             busy_q;

  logic        tick;
  logic        h_wrap;
  logic        v_wrap;
  logic [13:0] h_ext;
  logic [13:0] v_ext;
  logic        hsync_d;
  logic        vsync_d;
  logic [7:0]  data_d;

  assign tick    = (state_q == RUN) && (div_q == DIV_LAST);
  assign h_wrap  = (h_q == H_LAST);
  assign v_wrap  = (v_q == V_LAST);
  assign h_ext   = {1'b0, h_q};
  assign v_ext   = {2'b00, v_q};
  assign vsync_d = (v_ext < V_SYN_END);
  assign hsync_d = (v_ext >= V_ACT_BEG) && (v_ext < V_ACT_END) && (h_ext < H_ACT_END);

  always_comb begin
    data_d = 8'h00;
    if (hsync_d) begin
      case (pat_q)
        2'd0:    data_d = h_q[7:0];
        2'd1:    data_d = v_q[7:0];
        2'd2:    data_d = frame_q[7:0];
        default: data_d = h_q[0] ? 8'h5A : 8'hA5;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      pat_q    <= '0;
      frame_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        div_q <= '0;
        if (enable_in) begin
          state_q <= RUN;
          pat_q   <= pattern_sel_in;
          h_q     <= '0;
          v_q     <= '0;
          busy_q  <= 1'b1;
        end
      end else begin
        div_q <= tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          valid_q  <= 1'b1;
          data_q   <= data_d;
          hsync_q  <= hsync_d;
          vsync_q  <= vsync_d;
          hcount_q <= h_q;
          vcount_q <= v_q;
          if (!h_wrap) begin
            h_q <= h_q + 13'd1;
          end else begin
            h_q <= '0;
            if (!v_wrap) begin
              v_q <= v_q + 12'd1;
            end else begin
              // Last byte of the frame: count it and decide whether to run straight into the next one.
              v_q     <= '0;
              frame_q <= frame_q + 16'd1;
              if (enable_in) begin
                pat_q <= pattern_sel_in;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
      end
    end
  end

  assign cam.data_out        = data_q;
  assign cam.valid_byte_out  = valid_q;
  assign cam.hsync_out       = hsync_q;
  assign cam.vsync_out       = vsync_q;
  assign cam.hcount_out      = hcount_q;
  assign cam.vcount_out      = vcount_q;
  assign cam.frame_count_out = frame_q;
  assign cam.busy_out        = busy_q;

endmodule

// File: tb/tb_camera_stream_gen.sv
// Directed bench for camera_stream_gen: small geometry (12x7 bytes, CLK_DIV=2) plus a CLK_DIV=1, H_BLANK=1 instance.
module tb_camera_stream_gen;
  localparam int MAXC = 512;

  logic       clk;
  logic       rst_n;
  logic       en0, en1;
  logic [1:0] pat0, pat1;
  int         vecs;
  int         errs;

  int          ncap;
  int          cap_cyc [MAXC];
  int          cap_h   [MAXC];
  int          cap_v   [MAXC];
  logic        cap_hs  [MAXC];
  logic        cap_vs  [MAXC];
  logic [7:0]  cap_d   [MAXC];
  logic [15:0] fc_hist [MAXC];
  logic        busy_hist [MAXC];

  camera_stream_gen_if if0();
  camera_stream_gen_if if1();

  camera_stream_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_BLANK(4), .V_SYNC(1), .V_BACK(1),
                      .V_ACTIVE(4), .V_FRONT(1)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en0), .pattern_sel_in(pat0), .cam(if0));

  camera_stream_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_BLANK(1), .V_SYNC(1), .V_BACK(1),
                      .V_ACTIVE(4), .V_FRONT(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .enable_in(en1), .pattern_sel_in(pat1), .cam(if1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Samples one DUT for ncyc cycles (#1 after each edge); cycle c=1 is the first edge after the call.
  task automatic capture(input int sel, input int ncyc, input int chg_cyc, input logic chg_en,
                         input logic [1:0] chg_pat);
    logic s_v, s_hs, s_vs, s_busy;
    logic [7:0]  s_d;
    logic [12:0] s_h;
    logic [11:0] s_vc;
    logic [15:0] s_fc;
    ncap = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      if (sel == 0) begin
        s_v = if0.valid_byte_out; s_hs = if0.hsync_out; s_vs = if0.vsync_out; s_busy = if0.busy_out;
        s_d = if0.data_out; s_h = if0.hcount_out; s_vc = if0.vcount_out; s_fc = if0.frame_count_out;
      end else begin
        s_v = if1.valid_byte_out; s_hs = if1.hsync_out; s_vs = if1.vsync_out; s_busy = if1.busy_out;
        s_d = if1.data_out; s_h = if1.hcount_out; s_vc = if1.vcount_out; s_fc = if1.frame_count_out;
      end
      if (c < MAXC) begin
        fc_hist[c]   = s_fc;
        busy_hist[c] = s_busy;
      end
      if (s_v && ncap < MAXC) begin
        cap_cyc[ncap] = c; cap_h[ncap] = int'(s_h); cap_v[ncap] = int'(s_vc);
        cap_hs[ncap] = s_hs; cap_vs[ncap] = s_vs; cap_d[ncap] = s_d;
      end
      if (s_v) ncap++;
      if (c == chg_cyc) begin
        if (sel == 0) begin en0 = chg_en; pat0 = chg_pat; end
        else begin en1 = chg_en; pat1 = chg_pat; end
      end
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; pat0 = 2'd0; pat1 = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; pat0 = 2'd0; pat1 = 2'd0;
    repeat (2) @(negedge clk);
    vecs++; if (if0.data_out !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", if0.data_out); end
    vecs++; if (if0.valid_byte_out !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", if0.valid_byte_out); end
    vecs++; if (if0.hsync_out !== 1'b0) begin errs++; $display("FAIL reset_hsync: got %b want 0", if0.hsync_out); end
    vecs++; if (if0.vsync_out !== 1'b0) begin errs++; $display("FAIL reset_vsync: got %b want 0", if0.vsync_out); end
    vecs++; if (if0.hcount_out !== 13'd0) begin errs++; $display("FAIL reset_hcount: got %0d want 0", if0.hcount_out); end
    vecs++; if (if0.vcount_out !== 12'd0) begin errs++; $display("FAIL reset_vcount: got %0d want 0", if0.vcount_out); end
    vecs++; if (if0.frame_count_out !== 16'd0) begin errs++; $display("FAIL reset_frames: got %0d want 0", if0.frame_count_out); end
    vecs++; if (if0.busy_out !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", if0.busy_out); end
    vecs++; if (if1.valid_byte_out !== 1'b0) begin errs++; $display("FAIL reset_valid_fast: got %b want 0", if1.valid_byte_out); end
    rst_n = 1'b1;
    capture(0, 12, 0, 1'b0, 2'd0);
    vecs++; if (ncap !== 0) begin errs++; $display("FAIL idle_no_strobe: got %0d strobes want 0", ncap); end
    vecs++; if (busy_hist[12] !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", busy_hist[12]); end
  endtask

  // Two back-to-back frames, pattern 0 then 3 (changed mid-frame 1 at cycle 60).
  task automatic test_stream;
    int bad, eh, ev, nf, nvf;
    int falls [8];
    int vfalls [4];
    int rowhs [7];
    logic ehs;
    logic [7:0] ed;
    do_reset();
    en0 = 1'b1; pat0 = 2'd0;
    capture(0, 338, 60, 1'b1, 2'd3);
    vecs++; if (ncap !== 168) begin errs++; $display("FAIL stream_count: got %0d want 168", ncap); end
    vecs++; if (cap_cyc[0] !== 3) begin errs++; $display("FAIL first_byte_latency: got %0d want 3", cap_cyc[0]); end
    bad = 0;
    for (int i = 1; i < 168; i++) if (cap_cyc[i] - cap_cyc[i-1] != 2) bad++;
    vecs++; if (bad !== 0) begin errs++; $display("FAIL byte_interval: got %0d bad gaps want 0", bad); end
    bad = 0;
    for (int i = 0; i < 168; i++) if (cap_h[i] != i % 12 || cap_v[i] != (i / 12) % 7) bad++;
    vecs++; if (bad !== 0) begin errs++; $display("FAIL hv_sequence: got %0d bad bytes want 0", bad); end
    vecs++; if (fc_hist[168] !== 16'd0) begin errs++; $display("FAIL frames_before_last: got %0d want 0", fc_hist[168]); end
    vecs++; if (fc_hist[169] !== 16'd1) begin errs++; $display("FAIL frames_at_last: got %0d want 1", fc_hist[169]); end
    vecs++; if (fc_hist[337] !== 16'd2) begin errs++; $display("FAIL frames_second: got %0d want 2", fc_hist[337]); end
    vecs++; if (cap_h[84] !== 0 || cap_v[84] !== 0) begin errs++; $display("FAIL frame2_start: got h=%0d v=%0d want 0 0", cap_h[84], cap_v[84]); end
    for (int r = 0; r < 7; r++) rowhs[r] = 0;
    for (int i = 0; i < 84; i++) if (cap_hs[i]) rowhs[i / 12]++;
    for (int r = 0; r < 7; r++) begin
      vecs++;
      if (rowhs[r] !== ((r >= 2 && r <= 5) ? 8 : 0)) begin
        errs++; $display("FAIL hsync_row%0d: got %0d bytes want %0d", r, rowhs[r], (r >= 2 && r <= 5) ? 8 : 0);
      end
    end
    bad = 0;
    for (int i = 0; i < 168; i++) if (cap_vs[i] !== ((i / 12) % 7 == 0)) bad++;
    vecs++; if (bad !== 0) begin errs++; $display("FAIL vsync_rows: got %0d bad bytes want 0", bad); end
    nf = 0; nvf = 0;
    for (int i = 1; i < 168; i++) begin
      if (i < 84 && cap_hs[i-1] && !cap_hs[i] && nf < 8) begin falls[nf] = i; nf++; end
      if (cap_vs[i-1] && !cap_vs[i] && nvf < 4) begin vfalls[nvf] = i; nvf++; end
    end
    vecs++; if (nf !== 4) begin errs++; $display("FAIL hsync_falls: got %0d want 4", nf); end
    for (int k = 1; k < nf; k++) begin
      vecs++;
      if (falls[k] - falls[k-1] !== 12) begin errs++; $display("FAIL row_length%0d: got %0d want 12", k, falls[k] - falls[k-1]); end
    end
    vecs++;
    if (nvf !== 2) begin errs++; $display("FAIL vsync_falls: got %0d want 2", nvf); end
    else if (vfalls[1] - vfalls[0] !== 84) begin errs++; $display("FAIL frame_length: got %0d want 84", vfalls[1] - vfalls[0]); end
    bad = 0;
    for (int i = 0; i < 168; i++) begin
      eh = i % 12; ev = (i / 12) % 7;
      ehs = (ev >= 2 && ev <= 5 && eh < 8);
      if (!ehs) ed = 8'h00;
      else if (i < 84) ed = 8'(eh);
      else ed = (eh % 2 == 1) ? 8'h5A : 8'hA5;
      if (cap_hs[i] !== ehs || cap_d[i] !== ed) bad++;
    end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL pattern_data: got %0d bad bytes want 0", bad); end
    vecs++; if (cap_d[108] !== 8'hA5 || cap_d[109] !== 8'h5A) begin errs++; $display("FAIL pattern3_first: got %h %h want a5 5a", cap_d[108], cap_d[109]); end
  endtask

  task automatic test_enable_drop;
    int bad;
    logic [7:0] ed;
    do_reset();
    en0 = 1'b1; pat0 = 2'd1;
    capture(0, 220, 80, 1'b0, 2'd1);
    vecs++; if (ncap !== 84) begin errs++; $display("FAIL drop_count: got %0d want 84", ncap); end
    vecs++; if (cap_cyc[83] !== 169) begin errs++; $display("FAIL drop_last_cycle: got %0d want 169", cap_cyc[83]); end
    vecs++; if (busy_hist[168] !== 1'b1) begin errs++; $display("FAIL drop_busy_inframe: got %b want 1", busy_hist[168]); end
    vecs++; if (busy_hist[220] !== 1'b0) begin errs++; $display("FAIL drop_busy_after: got %b want 0", busy_hist[220]); end
    vecs++; if (fc_hist[220] !== 16'd1) begin errs++; $display("FAIL drop_frames: got %0d want 1", fc_hist[220]); end
    bad = 0;
    for (int i = 0; i < 84; i++) begin
      ed = ((i / 12) >= 2 && (i / 12) <= 5 && (i % 12) < 8) ? 8'(i / 12) : 8'h00;
      if (cap_d[i] !== ed) bad++;
    end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL pattern1_data: got %0d bad bytes want 0", bad); end
    en0 = 1'b1;
    capture(0, 6, 0, 1'b1, 2'd1);
    vecs++; if (ncap !== 2) begin errs++; $display("FAIL restart_count: got %0d want 2", ncap); end
    vecs++; if (cap_cyc[0] !== 3 || cap_h[0] !== 0 || cap_v[0] !== 0) begin
      errs++; $display("FAIL restart_first: got cyc=%0d h=%0d v=%0d want 3 0 0", cap_cyc[0], cap_h[0], cap_v[0]);
    end
  endtask

  task automatic test_async_reset;
    logic found;
    do_reset();
    en0 = 1'b1; pat0 = 2'd3;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clk);
      #1;
      if (if0.valid_byte_out && if0.vcount_out == 12'd2 && if0.hcount_out == 13'd5 && if0.frame_count_out == 16'd1)
        found = 1'b1;
    end
    vecs++; if (found !== 1'b1) begin errs++; $display("FAIL arst_locate: got %b want 1", found); end
    vecs++; if (if0.data_out !== 8'h5A || if0.hsync_out !== 1'b1) begin
      errs++; $display("FAIL arst_pre_byte: got %h/%b want 5a/1", if0.data_out, if0.hsync_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++; if ({if0.data_out, if0.valid_byte_out, if0.hsync_out, if0.vsync_out} !== 11'd0) begin
      errs++; $display("FAIL arst_byte_outs: got %h/%b/%b/%b want 0", if0.data_out, if0.valid_byte_out, if0.hsync_out, if0.vsync_out);
    end
    vecs++; if ({if0.hcount_out, if0.vcount_out, if0.frame_count_out, if0.busy_out} !== 42'd0) begin
      errs++; $display("FAIL arst_counters: got h=%0d v=%0d f=%0d b=%b want 0", if0.hcount_out, if0.vcount_out, if0.frame_count_out, if0.busy_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture(0, 6, 0, 1'b1, 2'd3);
    vecs++; if (cap_cyc[0] !== 3 || cap_h[0] !== 0 || cap_v[0] !== 0) begin
      errs++; $display("FAIL arst_restart: got cyc=%0d h=%0d v=%0d want 3 0 0", cap_cyc[0], cap_h[0], cap_v[0]);
    end
    vecs++; if (fc_hist[3] !== 16'd0) begin errs++; $display("FAIL arst_frames: got %0d want 0", fc_hist[3]); end
  endtask

  task automatic test_back_to_back;
    int bad, nf;
    int falls [8];
    do_reset();
    en1 = 1'b1; pat1 = 2'd0;
    capture(1, 127, 0, 1'b1, 2'd0);
    vecs++; if (ncap !== 126) begin errs++; $display("FAIL fast_count: got %0d want 126", ncap); end
    vecs++; if (cap_cyc[0] !== 2) begin errs++; $display("FAIL fast_latency: got %0d want 2", cap_cyc[0]); end
    bad = 0;
    for (int i = 1; i < 126; i++) if (cap_cyc[i] - cap_cyc[i-1] != 1) bad++;
    vecs++; if (bad !== 0) begin errs++; $display("FAIL fast_continuous: got %0d gaps want 0", bad); end
    bad = 0;
    for (int i = 0; i < 126; i++) if (cap_h[i] != i % 9 || cap_v[i] != (i / 9) % 7) bad++;
    vecs++; if (bad !== 0) begin errs++; $display("FAIL fast_sequence: got %0d bad bytes want 0", bad); end
    nf = 0;
    for (int i = 1; i < 63; i++) if (cap_hs[i-1] && !cap_hs[i] && nf < 8) begin falls[nf] = i; nf++; end
    vecs++; if (nf !== 4) begin errs++; $display("FAIL fast_hsync_falls: got %0d want 4", nf); end
    for (int k = 1; k < nf; k++) begin
      vecs++;
      if (falls[k] - falls[k-1] !== 9) begin errs++; $display("FAIL fast_row_length%0d: got %0d want 9", k, falls[k] - falls[k-1]); end
    end
    vecs++; if (fc_hist[63] !== 16'd0 || fc_hist[64] !== 16'd1) begin
      errs++; $display("FAIL fast_frame_edge: got %0d,%0d want 0,1", fc_hist[63], fc_hist[64]);
    end
    vecs++; if (fc_hist[127] !== 16'd2) begin errs++; $display("FAIL fast_frames: got %0d want 2", fc_hist[127]); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_stream();
    test_enable_drop();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
